// File: rtl/add64_result_buf_pkg.sv
// Shared constants and occupancy-state encoding for the adder result buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add64_result_buf_pkg;

  localparam int N_DEFAULT = 64;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } occ_state_e;

endpackage

// File: rtl/add64_flags.sv
// Derives carry-out, signed overflow and zero flags from a carry-select adder result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the flags are captured.
module add64_flags
  import add64_result_buf_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] i_s,
  input  logic         i_gen,
  input  logic         i_prop,
  input  logic         i_cin,
  input  logic         i_a_msb,
  input  logic         i_b_msb,
  output logic         o_cout,
  output logic         o_ovf,
  output logic         o_zero
);

  // Block carry resolves from generate/propagate and the applied carry-in.
  assign o_cout = i_gen | (i_prop & i_cin);

  // Overflow: operands share a sign but the sum's sign differs from it.
  assign o_ovf  = (i_a_msb == i_b_msb) && (i_s[N-1] != i_a_msb);

  assign o_zero = (i_s == '0);

endmodule

// File: rtl/add64_result_buf.sv
// Two-entry FIFO that captures adder sums plus derived flags for a downstream consumer.
// Latency: one cycle from accept to out_valid when empty; one result per cycle when streaming.
// Backpressure: in_ready drops when both entries are held; it is registered, independent of out_ready.
module add64_result_buf
  import add64_result_buf_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_s,
  input  logic         in_gen,
  input  logic         in_prop,
  input  logic         in_cin,
  input  logic         in_a_msb,
  input  logic         in_b_msb,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_s,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         out_zero
);

  // The head/tail register pair below is hard-wired for two entries.
  if (DEPTH != BUF_DEPTH) begin : g_depth_chk
    $error("add64_result_buf supports DEPTH == 2 only");
  end

  occ_state_e   r_state;
  occ_state_e   w_state_nxt;
  logic         r_not_full;
  logic         r_out_valid;

  logic [N-1:0] r_head_s;
  logic         r_head_cout;
  logic         r_head_ovf;
  logic         r_head_zero;
  logic [N-1:0] r_tail_s;
  logic         r_tail_cout;
  logic         r_tail_ovf;
  logic         r_tail_zero;

  logic         w_acc;
  logic         w_rel;
  logic         w_head_ld_new;
  logic         w_head_ld_tail;
  logic         w_tail_ld;
  logic         w_cout;
  logic         w_ovf;
  logic         w_zero;

  add64_flags #(.N(N)) u_flags (
    .i_s     (in_s),
    .i_gen   (in_gen),
    .i_prop  (in_prop),
    .i_cin   (in_cin),
    .i_a_msb (in_a_msb),
    .i_b_msb (in_b_msb),
    .o_cout  (w_cout),
    .o_ovf   (w_ovf),
    .o_zero  (w_zero)
  );

  // r_not_full is a register; gating with rst_n holds in_ready low while reset
  // is asserted yet lets it read 1 on the very first edge after release.
  assign in_ready  = r_not_full & rst_n;
  assign out_valid = r_out_valid;

  // Handshakes use the registered flags only, so nothing loops back to out_ready.
  assign w_acc = in_valid & r_not_full;
  assign w_rel = r_out_valid & out_ready;

  // Occupancy next state and which entry registers load this cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_head_ld_new  = 1'b0;
    w_head_ld_tail = 1'b0;
    w_tail_ld      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_state_nxt   = ONE;
          w_head_ld_new = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && w_rel) begin
          w_head_ld_new = 1'b1;
        end else if (w_acc) begin
          w_tail_ld   = 1'b1;
          w_state_nxt = FULL;
        end else if (w_rel) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_rel) begin
          w_head_ld_tail = 1'b1;
          w_state_nxt    = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State plus the handshake flags precomputed from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_not_full  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_not_full  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  // Head entry: loads a new result directly or promotes the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_s    <= '0;
      r_head_cout <= 1'b0;
      r_head_ovf  <= 1'b0;
      r_head_zero <= 1'b0;
    end else if (w_head_ld_new) begin
      r_head_s    <= in_s;
      r_head_cout <= w_cout;
      r_head_ovf  <= w_ovf;
      r_head_zero <= w_zero;
    end else if (w_head_ld_tail) begin
      r_head_s    <= r_tail_s;
      r_head_cout <= r_tail_cout;
      r_head_ovf  <= r_tail_ovf;
      r_head_zero <= r_tail_zero;
    end
  end

  // Tail entry: holds the second result while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail_s    <= '0;
      r_tail_cout <= 1'b0;
      r_tail_ovf  <= 1'b0;
      r_tail_zero <= 1'b0;
    end else if (w_tail_ld) begin
      r_tail_s    <= in_s;
      r_tail_cout <= w_cout;
      r_tail_ovf  <= w_ovf;
      r_tail_zero <= w_zero;
    end
  end

  assign out_s    = r_head_s;
  assign out_cout = r_head_cout;
  assign out_ovf  = r_head_ovf;
  assign out_zero = r_head_zero;

endmodule

// File: tb/tb_add64_result_buf.sv
// Self-checking bench for add64_result_buf: directed scenarios plus a random scoreboard run.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: out_ready driven per scenario, random in the soak test.
module tb_add64_result_buf;

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_s = '0;
  logic        in_gen = 1'b0;
  logic        in_prop = 1'b0;
  logic        in_cin = 1'b0;
  logic        in_a_msb = 1'b0;
  logic        in_b_msb = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_s;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int   n_checks = 0;
  int   n_pass = 0;
  res_t sb_q[$];
  logic acc;
  logic rel;
  res_t head;
  res_t exp_r;

  always #5 clk = ~clk;

  add64_result_buf #(.N(64), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_gen    (in_gen),
    .in_prop   (in_prop),
    .in_cin    (in_cin),
    .in_a_msb  (in_a_msb),
    .in_b_msb  (in_b_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  function automatic res_t model(input logic [63:0] s, input logic g, input logic p,
                                 input logic c, input logic am, input logic bm);
    res_t r;
    r.s    = s;
    r.cout = g | (p & c);
    r.ovf  = (am == bm) && (s[63] != am);
    r.zero = (s == 64'd0);
    return r;
  endfunction

  // Called just after a falling edge: records handshakes for the coming rising
  // edge, pushes accepted results, and returns the head as it was presented.
  task automatic tick(output logic t_acc, output logic t_rel, output res_t t_head);
    t_acc  = in_valid && in_ready;
    t_rel  = out_valid && out_ready;
    t_head = {out_s, out_cout, out_ovf, out_zero};
    if (t_acc) sb_q.push_back(model(in_s, in_gen, in_prop, in_cin, in_a_msb, in_b_msb));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    in_s     = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) in_s = '0;
    in_gen   = 1'($urandom_range(0, 1));
    in_prop  = 1'($urandom_range(0, 1));
    in_cin   = 1'($urandom_range(0, 1));
    in_a_msb = 1'($urandom_range(0, 1));
    in_b_msb = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++;
    if ({out_s, out_cout, out_ovf, out_zero} !== 67'd0)
      $display("FAIL rst_data got=%h exp=0", {out_s, out_cout, out_ovf, out_zero});
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", in_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_s = 64'd0; in_gen = 1'b0; in_prop = 1'b1; in_cin = 1'b1;
    in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b0;
    tick(acc, rel, head);
    in_valid = 1'b0;
    n_checks++;
    if (acc !== 1'b1) $display("FAIL single_accept got=%b exp=1", acc); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL single_latency got=%b exp=1", out_valid); else n_pass++;
    n_checks++;
    if ({out_cout, out_zero, out_ovf} !== 3'b110)
      $display("FAIL single_flags got=%b exp=110", {out_cout, out_zero, out_ovf});
    else n_pass++;
    out_ready = 1'b1;
    tick(acc, rel, head);
    out_ready = 1'b0;
    n_checks++;
    if (!rel || sb_q.size() == 0) $display("FAIL single_release got=%b exp=1", rel);
    else begin
      exp_r = sb_q.pop_front();
      if (head !== exp_r) $display("FAIL single_data got=%h exp=%h", head, exp_r); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; in_s = 64'h8000_0000_0000_0000; in_gen = 1'b0; in_prop = 1'b0; in_cin = 1'b1;
    in_a_msb = 1'b0; in_b_msb = 1'b0; out_ready = 1'b0;
    tick(acc, rel, head);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_ovf, out_cout, out_zero} !== 4'b1100)
      $display("FAIL ovf_flags got=%b exp=1100", {out_valid, out_ovf, out_cout, out_zero});
    else n_pass++;
    n_checks++;
    if (out_s !== 64'h8000_0000_0000_0000) $display("FAIL ovf_sum got=%h exp=8000000000000000", out_s);
    else n_pass++;
    out_ready = 1'b1;
    tick(acc, rel, head);
    out_ready = 1'b0;
    n_checks++;
    if (!rel || sb_q.size() == 0) $display("FAIL ovf_release got=%b exp=1", rel);
    else begin
      exp_r = sb_q.pop_front();
      if (head !== exp_r) $display("FAIL ovf_data got=%h exp=%h", head, exp_r); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic [63:0] rel_s [3];
    out_ready = 1'b0;
    in_gen = 1'b1; in_prop = 1'b0; in_cin = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_s = 64'(sent + 1);
      tick(acc, rel, head);
      if (acc) sent++;
    end
    n_checks++;
    if (sent !== 2) $display("FAIL bp_accepts got=%0d exp=2", sent); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++;
    if (out_s !== 64'd1) $display("FAIL bp_head_held got=%h exp=1", out_s); else n_pass++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
      in_valid = (sent < 3);
      in_s = 64'(sent + 1);
      tick(acc, rel, head);
      if (acc) sent++;
      if (rel) begin
        rel_s[got] = head.s;
        got++;
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL bp_underflow got=%h exp=none", head);
        else begin
          exp_r = sb_q.pop_front();
          if (head !== exp_r) $display("FAIL bp_data got=%h exp=%h", head, exp_r); else n_pass++;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got !== 3) $display("FAIL bp_release_count got=%0d exp=3", got);
    else if (rel_s[0] !== 64'd1 || rel_s[1] !== 64'd2 || rel_s[2] !== 64'd3)
      $display("FAIL bp_order got=%0d,%0d,%0d exp=1,2,3", rel_s[0], rel_s[1], rel_s[2]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    out_ready = 1'b1;
    while (got < 100 && cyc < 200) begin
      in_valid = (sent < 100);
      rand_inputs();
      tick(acc, rel, head);
      cyc++;
      if (acc) sent++;
      if (rel) begin
        got++;
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL stream_underflow got=%h exp=none", head);
        else begin
          exp_r = sb_q.pop_front();
          if (head !== exp_r) $display("FAIL stream_data got=%h exp=%h", head, exp_r); else n_pass++;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got !== 100 || cyc !== 101)
      $display("FAIL stream_rate got=%0d outputs in %0d cycles exp=100 in 101", got, cyc);
    else n_pass++;
  endtask

  task automatic test_reset_full();
    int stale = 0;
    out_ready = 1'b0;
    in_gen = 1'b0; in_prop = 1'b0; in_cin = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0;
    in_valid = 1'b1; in_s = 64'hAA;
    tick(acc, rel, head);
    in_s = 64'hBB;
    tick(acc, rel, head);
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01) $display("FAIL full_state got=%b exp=01", {in_ready, out_valid});
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b00) $display("FAIL async_rst got=%b exp=00", {in_ready, out_valid});
    else n_pass++;
    n_checks++;
    if (out_s !== 64'd0) $display("FAIL async_rst_data got=%h exp=0", out_s); else n_pass++;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      tick(acc, rel, head);
      if (rel) stale++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (stale !== 0) $display("FAIL stale_after_rst got=%0d exp=0", stale); else n_pass++;
  endtask

  task automatic test_random();
    logic prev_stall = 1'b0;
    logic stall_now;
    res_t prev_head = '0;
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      rand_inputs();
      out_ready = 1'($urandom_range(0, 1));
      n_checks++;
      if (out_valid !== (sb_q.size() != 0) || in_ready !== (sb_q.size() < 2))
        $display("FAIL rnd_occupancy got=v%b r%b exp=%0d entries", out_valid, in_ready, sb_q.size());
      else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if ({out_s, out_cout, out_ovf, out_zero} !== prev_head)
          $display("FAIL rnd_stall_stable got=%h exp=%h", {out_s, out_cout, out_ovf, out_zero}, prev_head);
        else n_pass++;
      end
      stall_now = out_valid && !out_ready;
      tick(acc, rel, head);
      prev_head = head;
      prev_stall = stall_now;
      if (rel) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL rnd_underflow got=%h exp=none", head);
        else begin
          exp_r = sb_q.pop_front();
          if (head !== exp_r) $display("FAIL rnd_data got=%h exp=%h", head, exp_r); else n_pass++;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      tick(acc, rel, head);
      if (rel) begin
        n_checks++;
        if (sb_q.size() == 0) $display("FAIL drain_underflow got=%h exp=none", head);
        else begin
          exp_r = sb_q.pop_front();
          if (head !== exp_r) $display("FAIL drain_data got=%h exp=%h", head, exp_r); else n_pass++;
        end
      end
    end
    out_ready = 1'b0;
    n_checks++;
    if (sb_q.size() !== 0) $display("FAIL drain_leftover got=%0d exp=0", sb_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish (%0d/%0d)", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
